// File: rtl/jtcop_bac06_pkg.sv
// Shared definitions for the BAC06 tile-map line renderer: FSM states,
// map word field positions and map-shape geometry.
package jtcop_bac06_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP,
    ST_MAP_W,
    ST_ROM,
    ST_DRAW
  } tmap_state_t;

  localparam int unsigned PAL_LSB     = 12;
  localparam int unsigned CODE_LSB    = 0;
  localparam int unsigned MODE_TILE16 = 2;

  // Column bits of the map address for a given shape; shape 3 aliases shape 2.
  function automatic int unsigned shape_cb(input int unsigned ram_aw, input logic [1:0] shape);
    int unsigned s;
    s = (shape == 2'd3) ? 32'd2 : 32'(shape);
    return ram_aw - 32'd4 - s;
  endfunction

endpackage

// File: rtl/jtcop_tmap_linebuf.sv
// Double-buffered 256-pixel line buffer: one bank is filled while the other
// is displayed and cleared behind the read.
module jtcop_tmap_linebuf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flip,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic       sel;
  logic [7:0] bank0 [256];
  logic [7:0] bank1 [256];

  // sel names the fill bank; the display bank is always the other one
  always_ff @(posedge clk) begin
    if (!rst_n) sel <= 1'b0;
    else if (flip) sel <= ~sel;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !sel) bank0[wr_addr] <= wr_data;
    else if (rd_en && sel) bank0[rd_addr] <= '0;
    if (wr_en && sel) bank1[wr_addr] <= wr_data;
    else if (rd_en && !sel) bank1[rd_addr] <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= sel ? bank0[rd_addr] : bank1[rd_addr];
  end

endmodule

// File: rtl/jtcop_bac06_tmap.sv
// BAC06 playfield line renderer: walks one map row per line, fetches tile
// ROM words and fills the line buffer, then streams palette pixels out.
module jtcop_bac06_tmap #(
  parameter int unsigned RAM_AW  = 11,
  parameter int unsigned ROM_AW  = 19,
  parameter int          HOFFSET = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic [2:0]        mode,
  input  logic [9:0]        scrx,
  input  logic [9:0]        scry,
  input  logic [8:0]        vrender,
  input  logic [8:0]        hdump,
  input  logic              LHBL,
  output logic [RAM_AW-1:0] map_addr,
  input  logic [15:0]       map_data,
  output logic              rom_cs,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              rom_ok,
  output logic [7:0]        pxl
);
  import jtcop_bac06_pkg::*;

  localparam logic [RAM_AW-1:0] ONE = RAM_AW'(1);

  tmap_state_t st, st_nx;
  logic        lhbl_l, line_start, tile16, last_pxl, line_done, wr_en;
  logic [2:0]  mode_l, cnt;
  logic [9:0]  scrx_l, scry_l, wptr, wptr_nx, x, y, col, row, pos;
  logic [8:0]  vrender_l;
  logic [3:0]  fine, fine_in, pal;
  logic [11:0] code;
  logic [31:0] word;
  logic [16:0] rom_raw;
  logic [7:0]  rd_addr, rd_data;
  int unsigned cb;

  assign line_start = lhbl_l & ~LHBL;
  assign tile16     = mode_l[MODE_TILE16];
  assign fine       = tile16 ? scrx_l[3:0] : {1'b0, scrx_l[2:0]};
  assign fine_in    = mode[MODE_TILE16] ? scrx[3:0] : {1'b0, scrx[2:0]};
  assign x          = scrx_l + wptr + {6'd0, fine};
  assign y          = scry_l + {1'b0, vrender_l};
  assign col        = tile16 ? x >> 4 : x >> 3;
  assign row        = tile16 ? y >> 4 : y >> 3;
  assign cb         = shape_cb(RAM_AW, mode_l[1:0]);
  // Row bits above the map height fall off the top of the address: vertical wrap
  assign map_addr   = (RAM_AW'(row) << cb) | (RAM_AW'(col) & ((ONE << cb) - ONE));
  assign rom_raw    = tile16 ? {code, x[3], y[3:0]} : {2'b00, code, y[2:0]};
  assign rom_addr   = ROM_AW'(rom_raw);

  assign wptr_nx    = wptr + 10'd8;
  assign line_done  = !wptr_nx[9] && wptr_nx[8];
  assign last_pxl   = cnt == 3'd7;
  assign pos        = wptr + {7'd0, cnt};
  assign wr_en      = (st == ST_DRAW) && (pos[9:8] == 2'b00);
  assign rd_addr    = 8'(hdump + 9'(HOFFSET));
  assign pxl        = LHBL ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) st <= ST_IDLE;
    else st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      ST_IDLE:  st_nx = ST_IDLE;
      ST_MAP:   st_nx = ST_MAP_W;
      ST_MAP_W: st_nx = ST_ROM;
      ST_ROM:   if (rom_ok) st_nx = ST_DRAW;
      ST_DRAW:
        if (last_pxl) begin
          if (line_done) st_nx = ST_IDLE;
          else if (tile16 && !x[3]) st_nx = ST_ROM;
          else st_nx = ST_MAP;
        end
      default:  st_nx = ST_IDLE;
    endcase
    if (line_start) st_nx = ST_MAP;
    // gated by rst_n so the request drops in the very cycle reset is asserted
    rom_cs = (st == ST_ROM) && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lhbl_l    <= LHBL;
      mode_l    <= '0;
      scrx_l    <= '0;
      scry_l    <= '0;
      vrender_l <= '0;
      wptr      <= '0;
      cnt       <= '0;
      pal       <= '0;
      code      <= '0;
      word      <= '0;
    end else begin
      lhbl_l <= LHBL;
      if (line_start) begin
        mode_l    <= mode;
        scrx_l    <= scrx;
        scry_l    <= scry;
        vrender_l <= vrender;
        wptr      <= 10'd0 - {6'd0, fine_in};
        cnt       <= '0;
      end else begin
        case (st)
          ST_MAP_W: begin
            pal  <= map_data[PAL_LSB +: 4];
            code <= map_data[CODE_LSB +: 12];
          end
          ST_ROM: if (rom_ok) begin
            word <= rom_data;
            cnt  <= '0;
          end
          ST_DRAW: begin
            word <= word << 4;
            cnt  <= cnt + 3'd1;
            if (last_pxl) wptr <= wptr_nx;
          end
          default: ;
        endcase
      end
    end
  end

  jtcop_tmap_linebuf u_linebuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flip    (line_start),
    .wr_en   (wr_en),
    .wr_addr (pos[7:0]),
    .wr_data ({pal, word[31:28]}),
    .rd_en   (pxl_cen),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_jtcop_bac06_tmap.sv
// Directed bench for jtcop_bac06_tmap: reset behaviour, tile rendering,
// scroll, 16x16 fetch order, map wrap and fetch abort.
module tb_jtcop_bac06_tmap;

  logic        clk = 1'b0;
  logic        rst_n, pxl_cen, LHBL, rom_cs;
  logic        rom_ok = 1'b0;
  logic [2:0]  mode;
  logic [9:0]  scrx, scry;
  logic [8:0]  vrender, hdump;
  logic [10:0] map_addr;
  logic [15:0] map_data = '0;
  logic [18:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic [7:0]  pxl;

  logic [15:0] map_mem [2048];
  logic [7:0]  cap [8][256];
  logic [18:0] addr_log [$];
  int unsigned base_log [8];
  int unsigned grant_used = 0;
  int unsigned grant_limit = 32'hFFFF_FFFF;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned scen;
    int unsigned pix;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [25];

  jtcop_bac06_tmap #(.RAM_AW(11), .ROM_AW(19), .HOFFSET(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .mode     (mode),
    .scrx     (scrx),
    .scry     (scry),
    .vrender  (vrender),
    .hdump    (hdump),
    .LHBL     (LHBL),
    .map_addr (map_addr),
    .map_data (map_data),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .pxl      (pxl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [18:0] a);
    case (a)
      19'd8:   return 32'h1234_5678;
      19'd16:  return 32'h9ABC_DEF1;
      19'd24:  return 32'hABCD_EF12;
      19'd69:  return 32'hFEDC_BA98;
      19'd85:  return 32'h1357_9BDF;
      default: return 32'h0;
    endcase
  endfunction

  // map RAM with one cycle of latency; ROM answers one cycle after a request
  always @(posedge clk) begin
    map_data <= map_mem[map_addr];
    rom_data <= rom_fn(rom_addr);
    rom_ok   <= rom_cs && !rom_ok && (grant_used < grant_limit);
    if (rom_cs && rom_ok) begin
      grant_used <= grant_used + 1;
      addr_log.push_back(rom_addr);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_rom(input logic need_ok);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (rom_cs && (rom_ok || !need_ok)) hit = 1'b1;
    end
    check("wait_rom", {31'd0, hit}, 32'd1);
  endtask

  // One line: fall of LHBL starts the fill with the given settings, then the
  // visible period captures what the previous line left in the display bank.
  task automatic run_line(input int unsigned idx, input logic [2:0] m, input logic [9:0] sx,
                          input logic [8:0] vr, input int unsigned lim);
    @(negedge clk);
    LHBL = 1'b1;
    pxl_cen = 1'b0;
    repeat (2) @(negedge clk);
    mode = m; scrx = sx; scry = '0; vrender = vr;
    base_log[idx] = addr_log.size();
    LHBL = 1'b0;
    @(negedge clk);
    grant_limit = (lim == 0) ? 32'hFFFF_FFFF : grant_used + lim;
    mode = 3'b111; scrx = 10'h155; scry = 10'h2AA; vrender = 9'h1AA;
    repeat (600) @(negedge clk);
    check($sformatf("blank_pxl[%0d]", idx), {24'd0, pxl}, 32'd0);
    LHBL = 1'b1;
    pxl_cen = 1'b1;
    for (int h = 0; h < 256; h++) begin
      hdump = 9'(h);
      @(negedge clk);
      cap[idx][h] = pxl;
    end
    pxl_cen = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned hi;
    for (int i = 0; i < 2048; i++) map_mem[i] = '0;
    vecs[0]  = '{1, 0, 8'h51};   vecs[1]  = '{1, 7, 8'h58};   vecs[2]  = '{1, 8, 8'h69};
    vecs[3]  = '{2, 0, 8'h54};   vecs[4]  = '{2, 4, 8'h58};   vecs[5]  = '{2, 5, 8'h69};
    vecs[6]  = '{2, 6, 8'h6A};
    vecs[7]  = '{3, 0, 8'h7F};   vecs[8]  = '{3, 7, 8'h78};   vecs[9]  = '{3, 8, 8'h71};
    vecs[10] = '{3, 15, 8'h7F};
    vecs[11] = '{4, 0, 8'h8A};   vecs[12] = '{4, 7, 8'h82};   vecs[13] = '{4, 8, 8'h51};
    vecs[14] = '{4, 15, 8'h58};
    vecs[15] = '{5, 0, 8'h8A};   vecs[16] = '{5, 8, 8'h51};
    vecs[17] = '{6, 0, 8'h51};   vecs[18] = '{6, 7, 8'h58};   vecs[19] = '{6, 8, 8'h00};
    vecs[20] = '{6, 200, 8'h00}; vecs[21] = '{6, 255, 8'h00};
    vecs[22] = '{7, 0, 8'h51};   vecs[23] = '{7, 7, 8'h58};   vecs[24] = '{7, 8, 8'h69};

    rst_n = 1'b0; LHBL = 1'b1; pxl_cen = 1'b0; hdump = '0;
    mode = '0; scrx = '0; scry = '0; vrender = '0;
    repeat (4) @(negedge clk);
    check("rst_pxl", {24'd0, pxl}, 32'd0);
    check("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    check("rst_map_addr", {21'd0, map_addr}, 32'd0);
    check("rst_rom_addr", {13'd0, rom_addr}, 32'd0);

    // reset in the middle of DRAW
    rst_n = 1'b1;
    map_mem[0] = 16'h5001;
    map_mem[1] = 16'h6002;
    repeat (2) @(negedge clk);
    LHBL = 1'b0;
    wait_rom(1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    LHBL = 1'b1;
    repeat (4) @(negedge clk);
    check("draw_rst_pxl", {24'd0, pxl}, 32'd0);
    check("draw_rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    check("draw_rst_rom_addr", {13'd0, rom_addr}, 32'd0);
    rst_n = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (rom_cs) hi++;
    end
    check("idle_after_rst", hi, 32'd0);

    // reset while the ROM request is outstanding
    LHBL = 1'b0;
    wait_rom(1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_cs_drop", {31'd0, rom_cs}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    run_line(0, 3'b000, 10'd0, 9'd0, 0);
    run_line(1, 3'b000, 10'd3, 9'd0, 0);
    map_mem[0] = 16'h7002;
    run_line(2, 3'b100, 10'd0, 9'd5, 0);
    if (addr_log.size() >= base_log[2] + 2) begin
      check("t16_rom_addr0", {13'd0, addr_log[base_log[2]]}, 32'd69);
      check("t16_rom_addr1", {13'd0, addr_log[base_log[2] + 1]}, 32'd85);
    end else begin
      check("t16_rom_fetches", addr_log.size() - base_log[2], 32'd2);
    end
    map_mem[0]  = 16'h5001;
    map_mem[31] = 16'h8003;
    run_line(3, 3'b010, 10'h3F8, 9'd0, 0);
    run_line(4, 3'b011, 10'h3F8, 9'd0, 0);
    run_line(5, 3'b000, 10'd0, 9'd0, 1);
    run_line(6, 3'b000, 10'd0, 9'd0, 0);
    run_line(7, 3'b000, 10'd0, 9'd0, 0);

    for (int i = 0; i < 25; i++) begin
      check($sformatf("line%0d_pxl%0d", vecs[i].scen, vecs[i].pix),
            {24'd0, cap[vecs[i].scen][vecs[i].pix]}, {24'd0, vecs[i].exp});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
